// File: rtl/decode_stage_param_pkg.sv
`default_nettype none
// ============================================================================
// rv_decode_pkg : shared opcode / ALU / result / immediate encodings and decoder
// Revision 1.0
// ============================================================================
package rv_decode_pkg;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_ialu   = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [3:0] c_alu_add   = 4'b0000;
    localparam logic [3:0] c_alu_sub   = 4'b0001;
    localparam logic [3:0] c_alu_and   = 4'b0010;
    localparam logic [3:0] c_alu_or    = 4'b0011;
    localparam logic [3:0] c_alu_xor   = 4'b0100;
    localparam logic [3:0] c_alu_slt   = 4'b0101;
    localparam logic [3:0] c_alu_sll   = 4'b0110;
    localparam logic [3:0] c_alu_srl   = 4'b0111;
    localparam logic [3:0] c_alu_sra   = 4'b1000;
    localparam logic [3:0] c_alu_passb = 4'b1001;

    localparam logic [1:0] c_res_alu   = 2'b00;
    localparam logic [1:0] c_res_mem   = 2'b01;
    localparam logic [1:0] c_res_pc4   = 2'b10;

    localparam logic [2:0] c_imm_i     = 3'b000;
    localparam logic [2:0] c_imm_s     = 3'b001;
    localparam logic [2:0] c_imm_b     = 3'b010;
    localparam logic [2:0] c_imm_j     = 3'b011;
    localparam logic [2:0] c_imm_u     = 3'b100;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic       illegal;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
    } ex_ctrl_t;

    function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt,
                                          input logic is_rtype);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = (is_rtype && alt) ? c_alu_sub : c_alu_add;
            3'b001:  op = c_alu_sll;
            3'b100:  op = c_alu_xor;
            3'b101:  op = alt ? c_alu_sra : c_alu_srl;
            3'b110:  op = c_alu_or;
            3'b111:  op = c_alu_and;
            default: op = c_alu_slt;  // 010, and 011 since there is no unsigned compare
        endcase
        return op;
    endfunction

    function automatic ex_ctrl_t decode_ctrl(input logic [31:0] instr);
        ex_ctrl_t c;
        c = '0;
        case (instr[6:0])
            c_op_load: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = c_res_mem;
                c.alu_ctrl   = c_alu_add;
            end
            c_op_store: begin
                c.mem_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_ctrl   = c_alu_add;
            end
            c_op_rtype: begin
                c.reg_write  = 1'b1;
                c.alu_ctrl   = alu_op(instr[14:12], instr[30], 1'b1);
            end
            c_op_ialu: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_ctrl   = alu_op(instr[14:12], instr[30], 1'b0);
            end
            c_op_branch: begin
                c.branch     = 1'b1;
                c.alu_ctrl   = c_alu_sub;
            end
            c_op_jal: begin
                c.jump       = 1'b1;
                c.reg_write  = 1'b1;
                c.result_src = c_res_pc4;
                c.alu_ctrl   = c_alu_add;
            end
            c_op_lui: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_ctrl   = c_alu_passb;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
        logic [2:0] sel;
        case (opcode)
            c_op_store:  sel = c_imm_s;
            c_op_branch: sel = c_imm_b;
            c_op_jal:    sel = c_imm_j;
            c_op_lui:    sel = c_imm_u;
            default:     sel = c_imm_i;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_param_if.sv
`default_nettype none
// ============================================================================
// decode_stage_param_if : decode-side inputs, writeback port and ID/EX outputs
// Revision 1.0
// ============================================================================
interface decode_stage_param_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            ValidD;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            EnE;
    logic            FlushE;
    logic            RegWriteW;
    logic [AW-1:0]   RDW;
    logic [XLEN-1:0] ResultW;

    logic            ValidE;
    logic            IllegalE;
    logic            BranchE;
    logic            JumpE;
    logic            MemWriteE;
    logic            ALUSrcE;
    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [AW-1:0]   Rs1E;
    logic [AW-1:0]   Rs2E;
    logic [AW-1:0]   RdE;
    logic            LoadUseStall;

    modport master (
        output ValidD, InstrD, PCD, PCPlus4D, EnE, FlushE, RegWriteW, RDW, ResultW,
        input  ValidE, IllegalE, BranchE, JumpE, MemWriteE, ALUSrcE, RegWriteE,
               ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               Rs1E, Rs2E, RdE, LoadUseStall
    );

    modport slave (
        input  ValidD, InstrD, PCD, PCPlus4D, EnE, FlushE, RegWriteW, RDW, ResultW,
        output ValidE, IllegalE, BranchE, JumpE, MemWriteE, ALUSrcE, RegWriteE,
               ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               Rs1E, Rs2E, RdE, LoadUseStall
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage_param_regfile_bypass.sv
`default_nettype none
// ============================================================================
// regfile_bypass : NREG x XLEN register file, x0 hardwired, write-first reads
// Revision 1.0
// ============================================================================
module regfile_bypass #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [$clog2(NREG)-1:0] waddr_i,
    input  logic [XLEN-1:0]         wdata_i,
    input  logic [$clog2(NREG)-1:0] raddr1_i,
    input  logic [$clog2(NREG)-1:0] raddr2_i,
    output logic [XLEN-1:0]         rdata1_o,
    output logic [XLEN-1:0]         rdata2_o
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic            w_wr_en;

    assign w_wr_en = we_i && (waddr_i != '0);

    // Reset wins over a simultaneous writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        if (raddr1_i == AW'(0)) begin
            rdata1_o = '0;
        end else if (w_wr_en && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = mem_q[raddr2_i];
        if (raddr2_i == AW'(0)) begin
            rdata2_o = '0;
        end else if (w_wr_en && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end
endmodule
`default_nettype wire

// File: rtl/decode_stage_param.sv
`default_nettype none
// ============================================================================
// decode_stage_param : RV decode, register read and ID/EX pipeline register
// Revision 1.0
// ============================================================================
module decode_stage_param
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_stage_param_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    typedef struct packed {
        logic            valid;
        ex_ctrl_t        ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
    } ex_reg_t;

    ex_reg_t            ex_q;
    ex_reg_t            ex_d;
    ex_ctrl_t           w_ctrl;
    logic [2:0]         w_imm_src;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic [AW-1:0]      w_rs1;
    logic [AW-1:0]      w_rs2;
    logic [AW-1:0]      w_rd;
    logic [XLEN-1:0]    w_rd1;
    logic [XLEN-1:0]    w_rd2;

    assign w_ctrl    = decode_ctrl(bus.InstrD);
    assign w_imm_src = imm_sel(bus.InstrD[6:0]);
    assign w_rs1     = bus.InstrD[15 +: AW];
    assign w_rs2     = bus.InstrD[20 +: AW];
    assign w_rd      = bus.InstrD[7 +: AW];

    // Build a 32-bit signed immediate, then let the cast sign-extend to XLEN
    always_comb begin
        w_imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
        case (w_imm_src)
            c_imm_s: w_imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            c_imm_b: w_imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                                bus.InstrD[11:8], 1'b0};
            c_imm_j: w_imm32 = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                                bus.InstrD[30:21], 1'b0};
            c_imm_u: w_imm32 = {bus.InstrD[31:12], 12'h000};
            default: w_imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
        endcase
    end

    assign w_imm = XLEN'(w_imm32);

    regfile_bypass #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.RegWriteW),
        .waddr_i  (bus.RDW),
        .wdata_i  (bus.ResultW),
        .raddr1_i (w_rs1),
        .raddr2_i (w_rs2),
        .rdata1_o (w_rd1),
        .rdata2_o (w_rd2)
    );

    // Bubble clears only valid/controls; data fields keep whatever they held
    always_comb begin
        ex_d = ex_q;
        if (bus.FlushE || (bus.EnE && !bus.ValidD)) begin
            ex_d.valid = 1'b0;
            ex_d.ctrl  = '0;
        end else if (bus.EnE) begin
            ex_d.valid = 1'b1;
            ex_d.ctrl  = w_ctrl;
            ex_d.rd1   = w_rd1;
            ex_d.rd2   = w_rd2;
            ex_d.imm   = w_imm;
            ex_d.pc    = bus.PCD;
            ex_d.pc4   = bus.PCPlus4D;
            ex_d.rs1   = w_rs1;
            ex_d.rs2   = w_rs2;
            ex_d.rd    = w_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ValidE      = ex_q.valid;
    assign bus.IllegalE    = ex_q.ctrl.illegal;
    assign bus.BranchE     = ex_q.ctrl.branch;
    assign bus.JumpE       = ex_q.ctrl.jump;
    assign bus.MemWriteE   = ex_q.ctrl.mem_write;
    assign bus.ALUSrcE     = ex_q.ctrl.alu_src;
    assign bus.RegWriteE   = ex_q.ctrl.reg_write;
    assign bus.ResultSrcE  = ex_q.ctrl.result_src;
    assign bus.ALUControlE = ex_q.ctrl.alu_ctrl;
    assign bus.RD1E        = ex_q.rd1;
    assign bus.RD2E        = ex_q.rd2;
    assign bus.ImmExtE     = ex_q.imm;
    assign bus.PCE         = ex_q.pc;
    assign bus.PCPlus4E    = ex_q.pc4;
    assign bus.Rs1E        = ex_q.rs1;
    assign bus.Rs2E        = ex_q.rs2;
    assign bus.RdE         = ex_q.rd;

    assign bus.LoadUseStall = ex_q.valid && (ex_q.ctrl.result_src == c_res_mem) &&
                              (ex_q.rd != AW'(0)) && bus.ValidD &&
                              ((ex_q.rd == w_rs1) || (ex_q.rd == w_rs2));
endmodule
`default_nettype wire

// File: tb/tb_decode_stage_param.sv
`default_nettype none
// Scoreboard bench: two configurations (32/32 and 64/16) share one stimulus stream,
// each checked against its own behavioural model.
module tb_decode_stage_param;

    typedef struct packed {
        logic        valid, illegal, reg_write, mem_write, branch, jump, alu_src;
        logic [1:0]  res_src;
        logic [3:0]  alu;
        logic [63:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        data_known, imm_known;
    } ex_t;

    typedef struct packed {
        ex_t  ex;
        logic stall;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_param_if #(.XLEN(32), .NREG(32)) if_a ();
    decode_stage_param_if #(.XLEN(64), .NREG(16)) if_b ();

    decode_stage_param #(.XLEN(32), .NREG(32)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    decode_stage_param #(.XLEN(64), .NREG(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    int          checks   = 0;
    int          failures = 0;
    item_t       q_a [$];
    item_t       q_b [$];
    ex_t         ex_m [2];
    logic [63:0] regs_m [2][32];

    function automatic logic [63:0] xmask(input int k);
        return (k == 0) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
    endfunction

    function automatic logic [4:0] ridx(input int k, input logic [4:0] f);
        return (k == 0) ? f : {1'b0, f[3:0]};
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic rtype);
        case (f3)
            3'b000:  return (rtype && alt) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0110;
            3'b100:  return 4'b0100;
            3'b101:  return alt ? 4'b1000 : 4'b0111;
            3'b110:  return 4'b0011;
            3'b111:  return 4'b0010;
            default: return 4'b0101;
        endcase
    endfunction

    function automatic ex_t model_decode(input logic [31:0] ins);
        ex_t                e;
        logic signed [11:0] i_imm, s_imm;
        logic signed [12:0] b_imm;
        logic signed [20:0] j_imm;
        logic signed [31:0] u_imm;
        i_imm = ins[31:20];
        s_imm = {ins[31:25], ins[11:7]};
        b_imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j_imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        u_imm = {ins[31:12], 12'h000};
        e = '0;
        e.valid = 1'b1;
        e.imm_known = 1'b1;
        case (ins[6:0])
            7'b0000011: begin e.reg_write = 1; e.alu_src = 1; e.res_src = 2'b01; e.imm = 64'(i_imm); end
            7'b0100011: begin e.mem_write = 1; e.alu_src = 1; e.imm = 64'(s_imm); end
            7'b0110011: begin e.reg_write = 1; e.alu = alu_of(ins[14:12], ins[30], 1'b1); e.imm_known = 0; end
            7'b0010011: begin e.reg_write = 1; e.alu_src = 1; e.alu = alu_of(ins[14:12], ins[30], 1'b0);
                              e.imm = 64'(i_imm); end
            7'b1100011: begin e.branch = 1; e.alu = 4'b0001; e.imm = 64'(b_imm); end
            7'b1101111: begin e.jump = 1; e.reg_write = 1; e.res_src = 2'b10; e.imm = 64'(j_imm); end
            7'b0110111: begin e.reg_write = 1; e.alu_src = 1; e.alu = 4'b1001; e.imm = 64'(u_imm); end
            default:    begin e.illegal = 1; e.imm_known = 0; end
        endcase
        return e;
    endfunction

    function automatic logic [63:0] rd_model(input int k, input logic [4:0] f, input logic rw,
                                             input logic [4:0] rdw, input logic [63:0] resw);
        logic [4:0] i, w;
        i = ridx(k, f);
        w = ridx(k, rdw);
        if (i == 5'd0) return 64'd0;
        if (rw && (w != 5'd0) && (w == i)) return resw & xmask(k);
        return regs_m[k][i];
    endfunction

    task automatic step(input logic r, input logic vd, input logic [31:0] ins, input logic en,
                        input logic fl, input logic rw, input logic [4:0] rdw, input logic [63:0] resw);
        logic [63:0] pc;
        item_t       it;
        ex_t         d;
        pc = {$urandom, $urandom} & ~64'h3;
        rst = r;
        if_a.ValidD = vd; if_a.InstrD = ins; if_a.PCD = pc[31:0]; if_a.PCPlus4D = pc[31:0] + 32'd4;
        if_a.EnE = en; if_a.FlushE = fl; if_a.RegWriteW = rw; if_a.RDW = rdw; if_a.ResultW = resw[31:0];
        if_b.ValidD = vd; if_b.InstrD = ins; if_b.PCD = pc; if_b.PCPlus4D = pc + 64'd4;
        if_b.EnE = en; if_b.FlushE = fl; if_b.RegWriteW = rw; if_b.RDW = rdw[3:0]; if_b.ResultW = resw;
        for (int k = 0; k < 2; k++) begin
            it.ex = ex_m[k];
            it.stall = ex_m[k].valid && (ex_m[k].res_src == 2'b01) && (ex_m[k].rd != 5'd0) && vd &&
                       ((ex_m[k].rd == ridx(k, ins[19:15])) || (ex_m[k].rd == ridx(k, ins[24:20])));
            if (k == 0) q_a.push_back(it); else q_b.push_back(it);
            d = ex_m[k];
            if (r) begin
                d = '0;
                d.data_known = 1'b1;
                d.imm_known = 1'b1;
            end else if (fl || (en && !vd)) begin
                d = '0;
            end else if (en) begin
                d = model_decode(ins);
                d.imm = d.imm & xmask(k);
                if (!d.illegal) begin
                    d.data_known = 1'b1;
                    d.rd1 = rd_model(k, ins[19:15], rw, rdw, resw);
                    d.rd2 = rd_model(k, ins[24:20], rw, rdw, resw);
                    d.pc  = pc & xmask(k);
                    d.pc4 = (pc + 64'd4) & xmask(k);
                    d.rs1 = ridx(k, ins[19:15]);
                    d.rs2 = ridx(k, ins[24:20]);
                    d.rd  = ridx(k, ins[11:7]);
                end
            end
            if (r) begin
                for (int i = 0; i < 32; i++) regs_m[k][i] = 64'd0;
            end else if (rw && (ridx(k, rdw) != 5'd0)) begin
                regs_m[k][ridx(k, rdw)] = resw & xmask(k);
            end
            ex_m[k] = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cfg %0d) t=%0t actual=%h required=%h", nm, k, $time, act, exp);
        end
    endtask

    task automatic compare(input int k, input ex_t a, input logic st, input item_t it);
        chk(k, "ValidE",       64'(a.valid),     64'(it.ex.valid));
        chk(k, "IllegalE",     64'(a.illegal),   64'(it.ex.illegal));
        chk(k, "RegWriteE",    64'(a.reg_write), 64'(it.ex.reg_write));
        chk(k, "MemWriteE",    64'(a.mem_write), 64'(it.ex.mem_write));
        chk(k, "BranchE",      64'(a.branch),    64'(it.ex.branch));
        chk(k, "JumpE",        64'(a.jump),      64'(it.ex.jump));
        chk(k, "ALUSrcE",      64'(a.alu_src),   64'(it.ex.alu_src));
        chk(k, "ResultSrcE",   64'(a.res_src),   64'(it.ex.res_src));
        chk(k, "ALUControlE",  64'(a.alu),       64'(it.ex.alu));
        chk(k, "LoadUseStall", 64'(st),          64'(it.stall));
        if (it.ex.data_known) begin
            chk(k, "RD1E",     a.rd1, it.ex.rd1);
            chk(k, "RD2E",     a.rd2, it.ex.rd2);
            chk(k, "PCE",      a.pc,  it.ex.pc);
            chk(k, "PCPlus4E", a.pc4, it.ex.pc4);
            chk(k, "Rs1E",     64'(a.rs1), 64'(it.ex.rs1));
            chk(k, "Rs2E",     64'(a.rs2), 64'(it.ex.rs2));
            chk(k, "RdE",      64'(a.rd),  64'(it.ex.rd));
        end
        if (it.ex.imm_known) chk(k, "ImmExtE", a.imm, it.ex.imm);
    endtask

    always @(negedge clk) begin
        item_t it;
        ex_t   a;
        if (q_a.size() > 0) begin
            it = q_a.pop_front();
            a = '0;
            a.valid = if_a.ValidE; a.illegal = if_a.IllegalE; a.reg_write = if_a.RegWriteE;
            a.mem_write = if_a.MemWriteE; a.branch = if_a.BranchE; a.jump = if_a.JumpE;
            a.alu_src = if_a.ALUSrcE; a.res_src = if_a.ResultSrcE; a.alu = if_a.ALUControlE;
            a.rd1 = 64'(if_a.RD1E); a.rd2 = 64'(if_a.RD2E); a.imm = 64'(if_a.ImmExtE);
            a.pc = 64'(if_a.PCE); a.pc4 = 64'(if_a.PCPlus4E);
            a.rs1 = 5'(if_a.Rs1E); a.rs2 = 5'(if_a.Rs2E); a.rd = 5'(if_a.RdE);
            compare(0, a, if_a.LoadUseStall, it);
        end
        if (q_b.size() > 0) begin
            it = q_b.pop_front();
            a = '0;
            a.valid = if_b.ValidE; a.illegal = if_b.IllegalE; a.reg_write = if_b.RegWriteE;
            a.mem_write = if_b.MemWriteE; a.branch = if_b.BranchE; a.jump = if_b.JumpE;
            a.alu_src = if_b.ALUSrcE; a.res_src = if_b.ResultSrcE; a.alu = if_b.ALUControlE;
            a.rd1 = if_b.RD1E; a.rd2 = if_b.RD2E; a.imm = if_b.ImmExtE;
            a.pc = if_b.PCE; a.pc4 = if_b.PCPlus4E;
            a.rs1 = 5'(if_b.Rs1E); a.rs2 = 5'(if_b.Rs2E); a.rd = 5'(if_b.RdE);
            compare(1, a, if_b.LoadUseStall, it);
        end
    end

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs1, input logic [4:0] rs2);
        return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        ins = $urandom;
        ins[19:15] = rnd_reg();
        ins[24:20] = rnd_reg();
        ins[11:7]  = rnd_reg();
        if (ins[14:12] == 3'b011) ins[14:12] = 3'b010;
        case ($urandom_range(0, 7))
            0: ins[6:0] = 7'b0000011;
            1: ins[6:0] = 7'b0100011;
            2: begin ins[6:0] = 7'b0110011; ins[31:25] = ins[30] ? 7'b0100000 : 7'b0000000; end
            3: ins[6:0] = 7'b0010011;
            4: ins[6:0] = 7'b1100011;
            5: ins[6:0] = 7'b1101111;
            6: ins[6:0] = 7'b0110111;
            default: begin
                case ($urandom_range(0, 3))
                    0: ins[6:0] = 7'b1111111;
                    1: ins[6:0] = 7'b0010111;
                    2: ins[6:0] = 7'b1100111;
                    default: ins[6:0] = 7'b0000000;
                endcase
            end
        endcase
        return ins;
    endfunction

    initial begin
        rst = 1'b1;
        if_a.ValidD = 0; if_a.InstrD = 0; if_a.PCD = 0; if_a.PCPlus4D = 0; if_a.EnE = 0;
        if_a.FlushE = 0; if_a.RegWriteW = 0; if_a.RDW = 0; if_a.ResultW = 0;
        if_b.ValidD = 0; if_b.InstrD = 0; if_b.PCD = 0; if_b.PCPlus4D = 0; if_b.EnE = 0;
        if_b.FlushE = 0; if_b.RegWriteW = 0; if_b.RDW = 0; if_b.ResultW = 0;
        for (int k = 0; k < 2; k++) begin
            ex_m[k] = '0;
            ex_m[k].data_known = 1'b1;
            ex_m[k].imm_known = 1'b1;
            for (int i = 0; i < 32; i++) regs_m[k][i] = 64'd0;
        end
        @(posedge clk);
        #1;
        // Reset, then addi x2,x1,3 while x1<=5 is written back in the same cycle
        step(1, 0, 32'h0, 0, 0, 0, 5'd0, 64'd0);
        step(0, 1, {12'd3, 5'd1, 3'b000, 5'd2, 7'b0010011}, 1, 0, 1, 5'd1, 64'd5);
        // lw x5,0(x1) followed by add x6,x5,x4, then the x0-destination variant
        step(0, 1, {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011}, 1, 0, 0, 5'd0, 64'd0);
        step(0, 1, {7'b0, 5'd4, 5'd5, 3'b000, 5'd6, 7'b0110011}, 1, 0, 0, 5'd0, 64'd0);
        step(0, 1, {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011}, 1, 0, 0, 5'd0, 64'd0);
        step(0, 1, {7'b0, 5'd4, 5'd0, 3'b000, 5'd6, 7'b0110011}, 1, 0, 0, 5'd0, 64'd0);
        // beq imm -8, jal imm +2048, lui 0x12345, unsupported opcode
        step(0, 1, enc_b(13'h1FF8, 5'd1, 5'd2), 1, 0, 0, 5'd0, 64'd0);
        step(0, 1, enc_j(21'd2048, 5'd1), 1, 0, 0, 5'd0, 64'd0);
        step(0, 1, {20'h12345, 5'd3, 7'b0110111}, 1, 0, 0, 5'd0, 64'd0);
        step(0, 1, {25'h0AB_CDEF, 7'b1111111}, 1, 0, 0, 5'd0, 64'd0);
        step(0, 1, {12'h7FF, 5'd17, 3'b000, 5'd18, 7'b0010011}, 1, 0, 1, 5'd17, 64'hFFFF_FFFF_8000_0001);
        // Hold for three cycles, then flush while held
        for (int n = 0; n < 3; n++) step(0, 1, rnd_instr(), 0, 0, 1, rnd_reg(), {$urandom, $urandom});
        step(0, 1, rnd_instr(), 0, 1, 0, 5'd0, 64'd0);
        // Writeback to x0 is ignored and never bypassed
        step(0, 1, {12'd7, 5'd0, 3'b000, 5'd3, 7'b0010011}, 1, 0, 1, 5'd0, 64'hDEAD_BEEF);
        step(0, 1, {7'b0, 5'd0, 5'd0, 3'b000, 5'd7, 7'b0110011}, 1, 0, 0, 5'd0, 64'd0);
        // Reset during hold and during flush, with a concurrent writeback
        step(0, 1, rnd_instr(), 0, 0, 0, 5'd0, 64'd0);
        step(1, 1, rnd_instr(), 0, 0, 1, 5'd1, 64'd99);
        step(0, 1, {12'd0, 5'd1, 3'b000, 5'd2, 7'b0010011}, 1, 0, 0, 5'd0, 64'd0);
        step(1, 1, rnd_instr(), 1, 1, 1, 5'd2, 64'd77);
        step(0, 1, {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 1, 0, 0, 5'd0, 64'd0);
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, rnd_instr(),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
                 rnd_reg(), {$urandom, $urandom});
        end
        step(0, 0, 32'h0, 0, 0, 0, 5'd0, 64'd0);
        @(negedge clk);
        #1;
        checks++;
        if ((q_a.size() != 0) || (q_b.size() != 0)) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", q_a.size(), q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
